// File: rtl/mem_controller_storeless_pkg.sv
// mem_controller_storeless_pkg: control FSM encodings shared by the memory-controller variants.
package mem_controller_storeless_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    DONE    = 2'd2
  } mcState_t;
endpackage

// File: rtl/mem_controller_storeless_read_arbiter.sv
// mc_read_arbiter: fixed-priority one-hot grant, lowest index wins.
module mc_read_arbiter
  import mem_controller_storeless_pkg::*;
#(
  parameter int NUM_LOADS = 1
) (
  input  logic [NUM_LOADS-1:0] pValid,
  input  logic [NUM_LOADS-1:0] eligible,
  output logic [NUM_LOADS-1:0] grant
);
  logic [NUM_LOADS-1:0] req;
  assign req = pValid & eligible;
  // Two's-complement trick isolates the lowest set request bit.
  assign grant = req & (~req + NUM_LOADS'(1));
endmodule

// File: rtl/mem_controller_storeless.sv
// mem_controller_storeless: load-only BRAM controller with per-port buffering and kernel start/end FSM.
module mem_controller_storeless
  import mem_controller_storeless_pkg::*;
#(
  parameter int NUM_LOADS = 1,
  parameter int DATA_TYPE = 32,
  parameter int ADDR_TYPE = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           memStart_valid,
  output logic                           memStart_ready,
  output logic                           memEnd_valid,
  input  logic                           memEnd_ready,
  input  logic                           ctrlEnd_valid,
  output logic                           ctrlEnd_ready,
  input  logic [NUM_LOADS*ADDR_TYPE-1:0] ldAddr,
  input  logic [NUM_LOADS-1:0]           ldAddr_valid,
  output logic [NUM_LOADS-1:0]           ldAddr_ready,
  output logic [NUM_LOADS*DATA_TYPE-1:0] ldData,
  output logic [NUM_LOADS-1:0]           ldData_valid,
  input  logic [NUM_LOADS-1:0]           ldData_ready,
  input  logic [DATA_TYPE-1:0]           loadData,
  output logic                           loadEn,
  output logic [ADDR_TYPE-1:0]           loadAddr,
  output logic                           storeEn,
  output logic [ADDR_TYPE-1:0]           storeAddr,
  output logic [DATA_TYPE-1:0]           storeData
);
  logic [NUM_LOADS-1:0]                inflight, dataValid, eligible, grant;
  logic [NUM_LOADS-1:0][DATA_TYPE-1:0] dataReg;
  logic [ADDR_TYPE-1:0]                addrMux;
  logic                                allLoadsDone;
  mcState_t                            state, stateNext;
  // A port may issue only if its buffer will be free when the BRAM data lands.
  assign eligible = ~inflight & (~dataValid | ldData_ready) & {NUM_LOADS{~rst}};
  mc_read_arbiter #(.NUM_LOADS(NUM_LOADS)) u_arb (
    .pValid  (ldAddr_valid),
    .eligible(eligible),
    .grant   (grant)
  );
  always_comb begin
    addrMux = '0;
    for (int i = 0; i < NUM_LOADS; i++)
      addrMux |= grant[i] ? ldAddr[i*ADDR_TYPE +: ADDR_TYPE] : '0;
  end
  assign ldAddr_ready = grant;
  assign loadEn       = |grant;
  assign loadAddr     = addrMux;
  assign ldData       = dataReg;
  assign ldData_valid = dataValid;
  assign allLoadsDone = ~|inflight & ~|dataValid;
  assign storeEn      = 1'b0;
  assign storeAddr    = '0;
  assign storeData    = '0;
  // Capture wins over pop so a refill in the same cycle keeps the port valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight  <= '0;
      dataValid <= '0;
      dataReg   <= '0;
    end else begin
      inflight <= grant;
      for (int i = 0; i < NUM_LOADS; i++) begin
        if (inflight[i]) begin
          dataReg[i]   <= loadData;
          dataValid[i] <= 1'b1;
        end else if (ldData_ready[i]) begin
          dataValid[i] <= 1'b0;
        end
      end
    end
  end
  always_ff @(posedge clk) state <= rst ? IDLE : stateNext;
  always_comb begin
    memStart_ready = state == IDLE;
    ctrlEnd_ready  = state == RUNNING && allLoadsDone && !rst;
    memEnd_valid   = state == DONE && !rst;
    stateNext      = (state == IDLE && memStart_valid) ? RUNNING :
                     (state == RUNNING && ctrlEnd_valid && allLoadsDone) ? DONE :
                     (state == DONE && memEnd_ready) ? IDLE : state;
  end
endmodule

// File: tb/tb_mem_controller_storeless.sv
// tb_mem_controller_storeless: directed checks on a 1-port and a 3-port instance.
module tb_mem_controller_storeless;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   fails = 0;
  always #5 clk = ~clk;

  logic        s1Valid, s1Ready, e1Valid, e1Ready, c1Valid, c1Ready;
  logic [31:0] a1, d1, l1Data, l1Addr, st1Addr, st1Data;
  logic        a1Valid, a1Ready, d1Valid, d1Ready, l1En, st1En;

  logic        s3Valid, s3Ready, e3Valid, e3Ready, c3Valid, c3Ready;
  logic [95:0] a3, d3;
  logic [2:0]  a3Valid, a3Ready, d3Valid, d3Ready;
  logic [31:0] l3Data, l3Addr, st3Addr, st3Data;
  logic        l3En, st3En;

  mem_controller_storeless #(.NUM_LOADS(1), .DATA_TYPE(32), .ADDR_TYPE(32)) dut1 (
    .clk(clk), .rst(rst),
    .memStart_valid(s1Valid), .memStart_ready(s1Ready),
    .memEnd_valid(e1Valid), .memEnd_ready(e1Ready),
    .ctrlEnd_valid(c1Valid), .ctrlEnd_ready(c1Ready),
    .ldAddr(a1), .ldAddr_valid(a1Valid), .ldAddr_ready(a1Ready),
    .ldData(d1), .ldData_valid(d1Valid), .ldData_ready(d1Ready),
    .loadData(l1Data), .loadEn(l1En), .loadAddr(l1Addr),
    .storeEn(st1En), .storeAddr(st1Addr), .storeData(st1Data)
  );

  mem_controller_storeless #(.NUM_LOADS(3), .DATA_TYPE(32), .ADDR_TYPE(32)) dut3 (
    .clk(clk), .rst(rst),
    .memStart_valid(s3Valid), .memStart_ready(s3Ready),
    .memEnd_valid(e3Valid), .memEnd_ready(e3Ready),
    .ctrlEnd_valid(c3Valid), .ctrlEnd_ready(c3Ready),
    .ldAddr(a3), .ldAddr_valid(a3Valid), .ldAddr_ready(a3Ready),
    .ldData(d3), .ldData_valid(d3Valid), .ldData_ready(d3Ready),
    .loadData(l3Data), .loadEn(l3En), .loadAddr(l3Addr),
    .storeEn(st3En), .storeAddr(st3Addr), .storeData(st3Data)
  );

  // BRAM stand-in for the 3-port instance: word at addr is addr+0x1000, one cycle late.
  always_ff @(posedge clk) l3Data <= l3En ? l3Addr + 32'h1000 : 32'hDEADBEEF;

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a1 = 32'h4; a1Valid = 1'b1;
    a3 = {32'h3, 32'h2, 32'h1}; a3Valid = 3'b111;
    cyc(); cyc();
    #1;
    checks++; if (a3Ready !== 3'b000) begin fails++; $display("FAIL rst_ldAddr_ready3 got %b expected 000", a3Ready); end
    checks++; if (a1Ready !== 1'b0) begin fails++; $display("FAIL rst_ldAddr_ready1 got %b expected 0", a1Ready); end
    checks++; if (l3En !== 1'b0) begin fails++; $display("FAIL rst_loadEn got %b expected 0", l3En); end
    checks++; if (d3Valid !== 3'b000) begin fails++; $display("FAIL rst_ldData_valid got %b expected 000", d3Valid); end
    checks++; if (e3Valid !== 1'b0 || c3Ready !== 1'b0) begin fails++; $display("FAIL rst_fsm_outs got memEnd_valid=%b ctrlEnd_ready=%b expected 0/0", e3Valid, c3Ready); end
    a1Valid = 1'b0; a3Valid = 3'b000;
    cyc();
    rst = 1'b0;
    #1;
    checks++; if (s3Ready !== 1'b1) begin fails++; $display("FAIL idle_memStart_ready got %b expected 1", s3Ready); end
    checks++; if (d3 !== 96'h0 || d3Valid !== 3'b000) begin fails++; $display("FAIL idle_ldData got %h/%b expected 0/000", d3, d3Valid); end
    checks++; if (st3En !== 1'b0 || st3Addr !== 32'h0 || st3Data !== 32'h0) begin fails++; $display("FAIL store_zero got %b %h %h expected 0 0 0", st3En, st3Addr, st3Data); end
  endtask

  task automatic test_single_load();
    cyc();
    a1 = 32'h10; a1Valid = 1'b1; d1Ready = 1'b0;
    #1;
    checks++; if (a1Ready !== 1'b1) begin fails++; $display("FAIL single_grant got %b expected 1", a1Ready); end
    checks++; if (l1En !== 1'b1 || l1Addr !== 32'h10) begin fails++; $display("FAIL single_bram got en=%b addr=%h expected 1/00000010", l1En, l1Addr); end
    cyc();
    a1Valid = 1'b0; l1Data = 32'hCAFE;
    #1;
    checks++; if (d1Valid !== 1'b0 || l1En !== 1'b0) begin fails++; $display("FAIL single_t1 got valid=%b en=%b expected 0/0", d1Valid, l1En); end
    cyc();
    l1Data = 32'h0;
    #1;
    checks++; if (d1Valid !== 1'b1 || d1 !== 32'hCAFE) begin fails++; $display("FAIL single_data got %b/%h expected 1/0000cafe", d1Valid, d1); end
    d1Ready = 1'b1;
    cyc();
    #1;
    checks++; if (d1Valid !== 1'b0) begin fails++; $display("FAIL single_pop got %b expected 0", d1Valid); end
    d1Ready = 1'b0;
  endtask

  task automatic test_two_ports();
    cyc();
    a3 = {32'h300, 32'h200, 32'h100}; a3Valid = 3'b101; d3Ready = 3'b111;
    #1;
    checks++; if (a3Ready !== 3'b001 || l3Addr !== 32'h100) begin fails++; $display("FAIL two_grant0 got %b/%h expected 001/00000100", a3Ready, l3Addr); end
    cyc();
    a3Valid = 3'b100;
    #1;
    checks++; if (a3Ready !== 3'b100 || l3Addr !== 32'h300) begin fails++; $display("FAIL two_grant2 got %b/%h expected 100/00000300", a3Ready, l3Addr); end
    cyc();
    a3Valid = 3'b000;
    #1;
    checks++; if (d3Valid !== 3'b001 || d3[31:0] !== 32'h1100) begin fails++; $display("FAIL two_data0 got %b/%h expected 001/00001100", d3Valid, d3[31:0]); end
    cyc();
    #1;
    checks++; if (d3Valid !== 3'b100 || d3[95:64] !== 32'h1300) begin fails++; $display("FAIL two_data2 got %b/%h expected 100/00001300", d3Valid, d3[95:64]); end
    cyc();
    #1;
    checks++; if (d3Valid !== 3'b000) begin fails++; $display("FAIL two_drain got %b expected 000", d3Valid); end
  endtask

  task automatic test_backpressure();
    cyc();
    a3 = {32'h0, 32'h0, 32'h40}; a3Valid = 3'b001; d3Ready = 3'b000;
    #1;
    checks++; if (a3Ready !== 3'b001) begin fails++; $display("FAIL bp_grant got %b expected 001", a3Ready); end
    cyc();
    a3Valid = 3'b000;
    cyc();
    a3 = {32'h0, 32'h50, 32'h44}; a3Valid = 3'b011; d3Ready = 3'b010;
    #1;
    checks++; if (d3Valid[0] !== 1'b1 || d3[31:0] !== 32'h1040) begin fails++; $display("FAIL bp_data0 got %b/%h expected 1/00001040", d3Valid[0], d3[31:0]); end
    checks++; if (a3Ready !== 3'b010 || l3Addr !== 32'h50) begin fails++; $display("FAIL bp_port1_grant got %b/%h expected 010/00000050", a3Ready, l3Addr); end
    cyc();
    a3Valid = 3'b001;
    for (int k = 3; k <= 6; k++) begin
      #1;
      checks++; if (a3Ready !== 3'b000) begin fails++; $display("FAIL bp_hold_grant cycle %0d got %b expected 000", k, a3Ready); end
      checks++; if (d3Valid[0] !== 1'b1 || d3[31:0] !== 32'h1040) begin fails++; $display("FAIL bp_hold_data cycle %0d got %b/%h expected 1/00001040", k, d3Valid[0], d3[31:0]); end
      if (k == 4) begin
        checks++; if (d3Valid[1] !== 1'b1 || d3[63:32] !== 32'h1050) begin fails++; $display("FAIL bp_port1_data got %b/%h expected 1/00001050", d3Valid[1], d3[63:32]); end
      end
      if (k == 5) begin
        checks++; if (d3Valid[1] !== 1'b0) begin fails++; $display("FAIL bp_port1_pop got %b expected 0", d3Valid[1]); end
      end
      cyc();
    end
    d3Ready = 3'b001;
    #1;
    checks++; if (a3Ready !== 3'b001 || l3Addr !== 32'h44) begin fails++; $display("FAIL bp_release_grant got %b/%h expected 001/00000044", a3Ready, l3Addr); end
    cyc();
    a3Valid = 3'b000;
    #1;
    checks++; if (d3Valid[0] !== 1'b0) begin fails++; $display("FAIL bp_release_pop got %b expected 0", d3Valid[0]); end
    cyc();
    #1;
    checks++; if (d3Valid[0] !== 1'b1 || d3[31:0] !== 32'h1044) begin fails++; $display("FAIL bp_refill got %b/%h expected 1/00001044", d3Valid[0], d3[31:0]); end
    cyc();
    d3Ready = 3'b000;
    #1;
    checks++; if (d3Valid !== 3'b000) begin fails++; $display("FAIL bp_drain got %b expected 000", d3Valid); end
  endtask

  task automatic test_fsm();
    cyc();
    s3Valid = 1'b1;
    #1;
    checks++; if (s3Ready !== 1'b1) begin fails++; $display("FAIL fsm_start_ready got %b expected 1", s3Ready); end
    cyc();
    s3Valid = 1'b0;
    a3 = {32'h0, 32'h0, 32'h60}; a3Valid = 3'b001; d3Ready = 3'b000;
    #1;
    checks++; if (s3Ready !== 1'b0 || c3Ready !== 1'b1) begin fails++; $display("FAIL fsm_running got memStart_ready=%b ctrlEnd_ready=%b expected 0/1", s3Ready, c3Ready); end
    cyc();
    a3Valid = 3'b000; c3Valid = 1'b1;
    #1;
    checks++; if (c3Ready !== 1'b0) begin fails++; $display("FAIL fsm_ctrl_inflight got %b expected 0", c3Ready); end
    cyc();
    #1;
    checks++; if (c3Ready !== 1'b0) begin fails++; $display("FAIL fsm_ctrl_buffered got %b expected 0", c3Ready); end
    d3Ready = 3'b001;
    cyc();
    d3Ready = 3'b000;
    #1;
    checks++; if (c3Ready !== 1'b1 || e3Valid !== 1'b0) begin fails++; $display("FAIL fsm_ctrl_accept got ctrlEnd_ready=%b memEnd_valid=%b expected 1/0", c3Ready, e3Valid); end
    cyc();
    c3Valid = 1'b0; s3Valid = 1'b1;
    #1;
    checks++; if (e3Valid !== 1'b1 || s3Ready !== 1'b0) begin fails++; $display("FAIL fsm_done got memEnd_valid=%b memStart_ready=%b expected 1/0", e3Valid, s3Ready); end
    cyc();
    #1;
    checks++; if (e3Valid !== 1'b1) begin fails++; $display("FAIL fsm_done_hold got %b expected 1", e3Valid); end
    s3Valid = 1'b0; e3Ready = 1'b1;
    cyc();
    e3Ready = 1'b0;
    #1;
    checks++; if (e3Valid !== 1'b0 || s3Ready !== 1'b1) begin fails++; $display("FAIL fsm_back_idle got memEnd_valid=%b memStart_ready=%b expected 0/1", e3Valid, s3Ready); end
  endtask

  task automatic test_reset_mid();
    cyc();
    s3Valid = 1'b1;
    cyc();
    s3Valid = 1'b0;
    a3 = {32'h0, 32'h70, 32'h0}; a3Valid = 3'b010;
    #1;
    checks++; if (a3Ready !== 3'b010) begin fails++; $display("FAIL rmid_grant got %b expected 010", a3Ready); end
    cyc();
    rst = 1'b1;
    #1;
    checks++; if (a3Ready !== 3'b000 || l3En !== 1'b0) begin fails++; $display("FAIL rmid_in_reset got ready=%b en=%b expected 000/0", a3Ready, l3En); end
    checks++; if (e3Valid !== 1'b0 || c3Ready !== 1'b0) begin fails++; $display("FAIL rmid_fsm_outs got %b/%b expected 0/0", e3Valid, c3Ready); end
    cyc();
    rst = 1'b0; a3Valid = 3'b000;
    #1;
    checks++; if (d3Valid !== 3'b000 || s3Ready !== 1'b1) begin fails++; $display("FAIL rmid_after got valid=%b memStart_ready=%b expected 000/1", d3Valid, s3Ready); end
    cyc();
    #1;
    checks++; if (d3Valid !== 3'b000) begin fails++; $display("FAIL rmid_no_delivery got %b expected 000", d3Valid); end
  endtask

  initial begin
    s1Valid = 1'b0; e1Ready = 1'b0; c1Valid = 1'b0; d1Ready = 1'b0; l1Data = 32'h0;
    s3Valid = 1'b0; e3Ready = 1'b0; c3Valid = 1'b0; d3Ready = 3'b000;
    test_reset();
    test_single_load();
    test_two_ports();
    test_backpressure();
    test_fsm();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/mem_controller_storeless.md
MEM_CONTROLLER_STORELESS -- requirements
Module: mem_controller_storeless

Interface
REQ-001 Parameters SHALL be: NUM_LOADS, default 1, number of load access ports; DATA_TYPE, default 32, data width; ADDR_TYPE, default 32, address width.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 memStart_valid/memStart_ready  in/out  1/1  start-of-kernel control handshake.
REQ-005 memEnd_valid/memEnd_ready  out/in  1/1  end-of-memory-activity handshake.
REQ-006 ctrlEnd_valid/ctrlEnd_ready  in/out  1/1  "no more load requests" handshake.
REQ-007 ldAddr  in  NUM_LOADS*ADDR_TYPE  packed load addresses, port i at bits [i*ADDR_TYPE +: ADDR_TYPE].
REQ-008 ldAddr_valid/ldAddr_ready  in/out  NUM_LOADS each  per-port address handshake.
REQ-009 ldData  out  NUM_LOADS*DATA_TYPE  packed returned data, port i at bits [i*DATA_TYPE +: DATA_TYPE].
REQ-010 ldData_valid/ldData_ready  out/in  NUM_LOADS each  per-port data handshake.
REQ-011 loadData  in  DATA_TYPE  BRAM read data, valid exactly one cycle after loadEn.
REQ-012 loadEn  out  1  BRAM read enable; loadAddr  out  ADDR_TYPE  BRAM read address.
REQ-013 storeEn  out  1, storeAddr  out  ADDR_TYPE, storeData  out  DATA_TYPE: SHALL be constant zero.

Function
REQ-014 Port i SHALL be eligible when ldAddr_valid[i], inflight[i]=0, and (ldData_valid[i]=0 or ldData_ready[i]=1).
REQ-015 At most one port per cycle SHALL be granted: the lowest-index eligible port (fixed priority).
REQ-016 ldAddr_ready SHALL be one-hot-or-zero, equal to the grant vector; loadEn=|grant; loadAddr=granted port's address, zero when no grant.
REQ-017 A grant in cycle t SHALL set inflight[i] for cycle t+1; in t+1 loadData SHALL be captured into port i's data register, ldData_valid[i]=1 from t+2 (address-to-data latency 2).
REQ-018 ldData_valid[i] SHALL clear on ldData_valid[i]&ldData_ready[i] unless a capture for port i occurs in the same cycle, in which case it SHALL stay 1 with the new data.
REQ-019 ldData[i] SHALL hold stable while ldData_valid[i]=1 and ldData_ready[i]=0.
REQ-020 allLoadsDone SHALL be 1 when inflight==0 and ldData_valid==0.
REQ-021 Control FSM states SHALL be IDLE, RUNNING, DONE; reset state IDLE.
REQ-022 IDLE: memStart_ready=1; memStart_valid -> RUNNING.
REQ-023 RUNNING: ctrlEnd_ready=allLoadsDone; ctrlEnd_valid&allLoadsDone -> DONE; otherwise stay.
REQ-024 DONE: memEnd_valid=1; memEnd_ready -> IDLE; memStart_valid ignored.
REQ-025 memStart_ready, ctrlEnd_ready, memEnd_valid SHALL be 0 in all states not listed above.
REQ-026 Load requests SHALL be serviced in every FSM state.

Reset
REQ-027 On rst: state=IDLE, inflight=0, ldData_valid=0, data registers=0; loadEn, ldAddr_ready, memEnd_valid, ctrlEnd_ready=0 in that cycle.
REQ-028 Reset mid-operation SHALL discard in-flight and buffered loads; BRAM data returning the next cycle SHALL be ignored.

Structure
REQ-029 FSM state encodings SHALL live in the shared memory-controller package, common with the load/store controller variants.
REQ-030 Priority arbitration SHALL be a sub-module mc_read_arbiter (pValid, eligibility mask in; one-hot grant out); datapath and FSM stay in the top.

Verification
REQ-031 NUM_LOADS=1, ldAddr=0x10 valid at t, BRAM returns 0xCAFE at t+1 -> ldAddr_ready=1 at t, loadEn=1/loadAddr=0x10 at t, ldData=0xCAFE valid at t+2.
REQ-032 NUM_LOADS=3, ports 0 and 2 valid at t -> port 0 granted t, port 2 granted t+1; data delivered t+2 and t+3 on the correct ports.
REQ-033 Port 0 ldData_ready=0 for 5 cycles with new ldAddr valid -> no further grant to port 0, data held stable, port 1 still served.
REQ-034 memStart at t0, ctrlEnd_valid while one load outstanding -> ctrlEnd_ready=0 until data consumed, then ctrlEnd accepted, memEnd_valid=1 next cycle, held until memEnd_ready.
REQ-035 rst asserted in cycle after a grant -> ldData_valid=0, FSM IDLE, returning loadData not delivered.
